vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Raster timing generator feeding the background pixel generators and the final RGB mux in the scrolling-background peripheral.
- Produces hsync, vsync, visible and the pixel coordinates pix_x and pix_y; all outputs are coherent in the same cycle.
- Also produces line and frame strobes and a free-running frame counter that the backgrounds use for scroll animation.
- Defaults target 1024x768@60 on the 64 MHz TinyQV clock, one pixel per clk.

Parameters:
- H_VIS, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 136, hsync width (pixels)
- H_BP, 160, horizontal back porch (pixels); H_TOTAL = 1344
- V_VIS, 768, visible lines
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vsync width (lines)
- V_BP, 29, vertical back porch (lines); V_TOTAL = 806
- CLK_DIV, 1, clk cycles per pixel (1..4)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset: synchronous, active-low
- enable  in  1  run timing; low holds the generator idle
- polarity  in  1  sync active level (1 = active-high, 0 = active-low)
- hsync  out  1  horizontal sync, polarity-adjusted
- vsync  out  1  vertical sync, polarity-adjusted
- visible  out  1  high when pix_x < H_VIS and pix_y < V_VIS
- pix_x  out  11  horizontal count, 0..H_TOTAL-1
- pix_y  out  11  vertical count, 0..V_TOTAL-1
- line_end  out  1  one-cycle pulse on the last clk of pixel H_TOTAL-1
- frame_end  out  1  one-cycle pulse on the last clk of pixel (H_TOTAL-1, V_TOTAL-1)
- frame_cnt  out  8  frames completed since enable rose; wraps

Behaviour:
- All outputs are registered. Sync/visible are decoded from next-state counters so they align with pix_x/pix_y with zero relative skew.
- Reset and enable=0 both force:
  - pix_x = pix_y = 0, frame_cnt = 0, div counter = 0.
  - visible = 0, line_end = 0, frame_end = 0.
  - hsync = vsync = ~polarity (inactive).
- Pixel enable: a div counter runs 0..CLK_DIV-1 and pix_ce is asserted when it equals CLK_DIV-1. With CLK_DIV=1, pix_ce is constantly 1.
- Counters advance only on pix_ce:
  - pix_x increments; at H_TOTAL-1 it wraps to 0 and pix_y increments.
  - pix_y wraps to 0 after V_TOTAL-1; frame_cnt increments (mod 256) on that wrap.
- hsync is active iff H_VIS+H_FP <= pix_x < H_VIS+H_FP+H_SYNC (1048..1183 by default).
- vsync is active iff V_VIS+V_FP <= pix_y < V_VIS+V_FP+V_SYNC (771..776). vsync changes coincident with pix_x = 0.
- Active level of each sync = polarity.
- polarity is sampled every cycle, so a change takes effect on the sync outputs on the next clk. No glitch beyond a single level change.
- line_end = pix_ce & (pix_x == H_TOTAL-1). frame_end = line_end & (pix_y == V_TOTAL-1).
- Enable rising: the first cycle with enable=1 presents (0,0) with visible=1, and counting starts from there.
- Enable falling mid-frame: idle state on the next clk and no strobes. Re-enable restarts at (0,0) with frame_cnt = 0.
- rst_n overrides enable in all states.
- Counter widths are 11 bits, so H_TOTAL and V_TOTAL must be <= 2048. The compare logic never overflows.

Decomposition:
- Shared package vga_timing_pkg holds:
  - The XGA default constants (H_*/V_* values and totals).
  - The COORD_W = 11 constant.
  - Derived sync start/end localparams, reused by the background generators for visible-area bounds.
- One natural sub-module, vga_axis_counter, instantiated twice (horizontal, vertical).
  - Parameters: VIS, FP, SYNC, BP.
  - Inputs: clk, rst_n, clear, step.
  - Outputs: count, sync_raw, active, wrap.
  - The top adds the divider, polarity XOR, strobes and frame_cnt.

Test Plan:
- Reset → idle outputs: rst_n=0 with enable=1 → pix_x=pix_y=0, visible=0, hsync=vsync=0 (polarity=1), frame_cnt=0.
- Horizontal timing: enable=1, polarity=1, CLK_DIV=1, count one line → visible high for 1024 clks, hsync rises at pix_x=1048 and stays high 136 clks, line_end pulses once at pix_x=1343, period 1344 clks.
- Vertical wrap and frame counter: run 3 full frames → vsync high for lines 771..776 (6×1344 clks), frame_end pulses every 1083264 clks, frame_cnt reads 3, pix_y wraps from 805 to 0.
- Enable drop and restart: deassert enable at pix_x=500, pix_y=300 → next clk pix_x=pix_y=0, syncs inactive, no strobes; reassert → counting restarts at (0,0) with frame_cnt=0.
- Polarity 0: polarity=0 over one line → hsync low only for pix_x 1048..1183, high otherwise; vsync idles high.
- Divider: CLK_DIV=2 → pix_x increments every 2 clks, a line is 2688 clks, line_end is 1 clk wide.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared raster constants for the scrolling-background peripheral.
// XGA defaults plus derived sync windows used by the pixel generators.
package vga_timing_pkg;

  localparam int COORD_W = 11;

  typedef logic [COORD_W-1:0] coord_t;

  localparam int XGA_H_VIS  = 1024;
  localparam int XGA_H_FP   = 24;
  localparam int XGA_H_SYNC = 136;
  localparam int XGA_H_BP   = 160;

  localparam int XGA_V_VIS  = 768;
  localparam int XGA_V_FP   = 3;
  localparam int XGA_V_SYNC = 6;
  localparam int XGA_V_BP   = 29;

  localparam int XGA_H_TOTAL =
    XGA_H_VIS + XGA_H_FP + XGA_H_SYNC + XGA_H_BP;
  localparam int XGA_V_TOTAL =
    XGA_V_VIS + XGA_V_FP + XGA_V_SYNC + XGA_V_BP;

  localparam int XGA_H_SYNC_START = XGA_H_VIS + XGA_H_FP;
  localparam int XGA_H_SYNC_END   = XGA_H_SYNC_START + XGA_H_SYNC;
  localparam int XGA_V_SYNC_START = XGA_V_VIS + XGA_V_FP;
  localparam int XGA_V_SYNC_END   = XGA_V_SYNC_START + XGA_V_SYNC;

  function automatic int axis_total(
    input int vis,
    input int fp,
    input int sync,
    input int bp
  );
    return vis + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster bundle between the timing generator and its consumers.
// master = generator, slave = background/RGB-mux side.
interface vga_timing_if;
  import vga_timing_pkg::*;

  logic       enable;
  logic       polarity;
  logic       hsync;
  logic       vsync;
  logic       visible;
  coord_t     pix_x;
  coord_t     pix_y;
  logic       line_end;
  logic       frame_end;
  logic [7:0] frame_cnt;

  modport master (
    input  enable,
    input  polarity,
    output hsync,
    output vsync,
    output visible,
    output pix_x,
    output pix_y,
    output line_end,
    output frame_end,
    output frame_cnt
  );

  modport slave (
    output enable,
    output polarity,
    input  hsync,
    input  vsync,
    input  visible,
    input  pix_x,
    input  pix_y,
    input  line_end,
    input  frame_end,
    input  frame_cnt
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position register plus next-state sync/active decode.
// sync_raw/active describe the value count takes after this edge.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int VIS  = XGA_H_VIS,
  parameter int FP   = XGA_H_FP,
  parameter int SYNC = XGA_H_SYNC,
  parameter int BP   = XGA_H_BP
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clear,
  input  logic   step,
  output coord_t count,
  output logic   sync_raw,
  output logic   active,
  output logic   wrap
);

  localparam int TOTAL = axis_total(VIS, FP, SYNC, BP);

  localparam coord_t LAST    = coord_t'(TOTAL - 1);
  localparam coord_t VIS_C   = coord_t'(VIS);
  localparam coord_t SYNC_LO = coord_t'(VIS + FP);
  localparam coord_t SYNC_HI = coord_t'(VIS + FP + SYNC);
  localparam coord_t ONE     = coord_t'(1);

  coord_t nxt;
  logic   kill;
  logic   at_last;

  assign kill    = clear | ~rst_n;
  assign at_last = (count == LAST);
  assign wrap    = step & at_last;

  always_comb begin
    nxt = count;
    if (kill) begin
      nxt = '0;
    end else if (step) begin
      nxt = at_last ? '0 : count + ONE;
    end
  end

  always_comb begin
    sync_raw = 1'b0;
    active   = 1'b0;
    if (!kill) begin
      sync_raw = (nxt >= SYNC_LO) && (nxt < SYNC_HI);
      active   = (nxt < VIS_C);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= nxt;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: divider, two axis counters, registered
// sync/visible/strobe outputs and a free-running frame counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VIS   = XGA_H_VIS,
  parameter int H_FP    = XGA_H_FP,
  parameter int H_SYNC  = XGA_H_SYNC,
  parameter int H_BP    = XGA_H_BP,
  parameter int V_VIS   = XGA_V_VIS,
  parameter int V_FP    = XGA_V_FP,
  parameter int V_SYNC  = XGA_V_SYNC,
  parameter int V_BP    = XGA_V_BP,
  parameter int CLK_DIV = 1
) (
  input logic         clk,
  input logic         rst_n,
  vga_timing_if.master bus
);

  localparam int H_TOTAL = axis_total(H_VIS, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_VIS, V_FP, V_SYNC, V_BP);

  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t H_PEN  = coord_t'(H_TOTAL - 2);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

  localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);

  logic       run;
  logic [1:0] div;
  logic [1:0] div_nxt;
  logic       go;
  logic       pix_ce;
  logic       clear;

  coord_t x_cnt;
  coord_t y_cnt;
  logic   h_sync_raw;
  logic   v_sync_raw;
  logic   h_act;
  logic   v_act;
  logic   h_wrap;
  logic   v_wrap;

  logic x_nxt_last;
  logic line_end_nxt;
  logic frame_end_nxt;

  logic       hsync_q;
  logic       vsync_q;
  logic       visible_q;
  logic       line_end_q;
  logic       frame_end_q;
  logic [7:0] frame_cnt_q;

  assign clear  = ~bus.enable;
  assign go     = run & bus.enable;
  assign pix_ce = go & (div == DIV_LAST);

  // First enabled edge only loads (0,0); stepping begins after it.
  always_comb begin
    div_nxt = '0;
    if (go && (div != DIV_LAST)) begin
      div_nxt = div + 2'd1;
    end
  end

  vga_axis_counter #(
    .VIS  (H_VIS),
    .FP   (H_FP),
    .SYNC (H_SYNC),
    .BP   (H_BP)
  ) u_h (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .step     (pix_ce),
    .count    (x_cnt),
    .sync_raw (h_sync_raw),
    .active   (h_act),
    .wrap     (h_wrap)
  );

  vga_axis_counter #(
    .VIS  (V_VIS),
    .FP   (V_FP),
    .SYNC (V_SYNC),
    .BP   (V_BP)
  ) u_v (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .step     (h_wrap),
    .count    (y_cnt),
    .sync_raw (v_sync_raw),
    .active   (v_act),
    .wrap     (v_wrap)
  );

  // Strobes mark the last clk of the final pixel, so look one edge ahead.
  assign x_nxt_last = pix_ce ? (x_cnt == H_PEN)
                             : (x_cnt == H_LAST);
  assign line_end_nxt  = go & (div_nxt == DIV_LAST) & x_nxt_last;
  assign frame_end_nxt = line_end_nxt & (y_cnt == V_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || !bus.enable) begin
      run         <= 1'b0;
      div         <= '0;
      visible_q   <= 1'b0;
      line_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
      frame_cnt_q <= '0;
      hsync_q     <= ~bus.polarity;
      vsync_q     <= ~bus.polarity;
    end else begin
      run         <= 1'b1;
      div         <= div_nxt;
      visible_q   <= h_act & v_act;
      line_end_q  <= line_end_nxt;
      frame_end_q <= frame_end_nxt;
      hsync_q     <= h_sync_raw ? bus.polarity : ~bus.polarity;
      vsync_q     <= v_sync_raw ? bus.polarity : ~bus.polarity;
      if (v_wrap) begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
    end
  end

  assign bus.pix_x     = x_cnt;
  assign bus.pix_y     = y_cnt;
  assign bus.hsync     = hsync_q;
  assign bus.vsync     = vsync_q;
  assign bus.visible   = visible_q;
  assign bus.line_end  = line_end_q;
  assign bus.frame_end = frame_end_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: XGA line timing plus shrunken rasters
// for frame wrap, enable restart and the pixel divider.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic pol = 1'b1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vga_timing_if xga_if ();
  vga_timing_if sm_if ();
  vga_timing_if dv_if ();

  assign xga_if.enable   = en;
  assign xga_if.polarity = pol;
  assign sm_if.enable    = en;
  assign sm_if.polarity  = pol;
  assign dv_if.enable    = en;
  assign dv_if.polarity  = pol;

  vga_timing_gen u_xga (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (xga_if)
  );

  // 25 x 13 raster: hsync x 18..21, vsync y 9..10, frame 325 clks
  vga_timing_gen #(
    .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_VIS(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .CLK_DIV(1)
  ) u_sm (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sm_if)
  );

  vga_timing_gen #(
    .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_VIS(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .CLK_DIV(2)
  ) u_dv (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dv_if)
  );

  typedef struct {
    int cyc;
    int x;
    int y;
    int vis;
    int hs;
    int vs;
    int le;
    int fe;
    int fc;
  } vec_t;

  vec_t tbl[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Drop enable for one edge, then raise it; returns at cycle k = 0.
  task automatic start();
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
  endtask

  initial begin
    int k;
    int cnt_vis;
    int cnt_hs;
    int cnt_le;
    int cnt_vs;
    int first_hs;
    int le_x;

    //             cyc  x  y vis hs vs le fe fc
    tbl.push_back('{  0,  0,  0, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{ 15, 15,  0, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{ 16, 16,  0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{ 18, 18,  0, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{ 21, 21,  0, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{ 22, 22,  0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{ 24, 24,  0, 0, 0, 0, 1, 0, 0});
    tbl.push_back('{ 25,  0,  1, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{200,  0,  8, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{224, 24,  8, 0, 0, 0, 1, 0, 0});
    tbl.push_back('{225,  0,  9, 0, 0, 1, 0, 0, 0});
    tbl.push_back('{274, 24, 10, 0, 0, 1, 1, 0, 0});
    tbl.push_back('{275,  0, 11, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{324, 24, 12, 0, 0, 0, 1, 1, 0});
    tbl.push_back('{325,  0,  0, 1, 0, 0, 0, 0, 1});
    tbl.push_back('{974, 24, 12, 0, 0, 0, 1, 1, 2});
    tbl.push_back('{975,  0,  0, 1, 0, 0, 0, 0, 3});

    // Reset holds idle even with enable high
    tick();
    tick();
    tick();
    chk("rst pix_x", int'(xga_if.pix_x), 0);
    chk("rst pix_y", int'(xga_if.pix_y), 0);
    chk("rst visible", int'(xga_if.visible), 0);
    chk("rst hsync", int'(xga_if.hsync), 0);
    chk("rst vsync", int'(xga_if.vsync), 0);
    chk("rst frame_cnt", int'(xga_if.frame_cnt), 0);
    chk("rst line_end", int'(xga_if.line_end), 0);
    rst_n = 1'b1;

    // XGA line, active-high syncs
    start();
    cnt_vis = 0;
    cnt_hs = 0;
    cnt_le = 0;
    first_hs = -1;
    le_x = -1;
    for (int i = 0; i < 1344; i++) begin
      if (xga_if.visible) cnt_vis++;
      if (xga_if.hsync) begin
        cnt_hs++;
        if (first_hs < 0) first_hs = int'(xga_if.pix_x);
      end
      if (xga_if.line_end) begin
        cnt_le++;
        le_x = int'(xga_if.pix_x);
      end
      tick();
    end
    chk("xga visible clks", cnt_vis, 1024);
    chk("xga hsync clks", cnt_hs, 136);
    chk("xga hsync start", first_hs, 1048);
    chk("xga line_end pulses", cnt_le, 1);
    chk("xga line_end x", le_x, 1343);
    chk("xga wrap x", int'(xga_if.pix_x), 0);
    chk("xga wrap y", int'(xga_if.pix_y), 1);

    // Small raster: table of expected states over three frames
    start();
    k = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      while (k < tbl[i].cyc) begin
        tick();
        k++;
      end
      chk($sformatf("tbl%0d x", k), int'(sm_if.pix_x), tbl[i].x);
      chk($sformatf("tbl%0d y", k), int'(sm_if.pix_y), tbl[i].y);
      chk($sformatf("tbl%0d vis", k), int'(sm_if.visible), tbl[i].vis);
      chk($sformatf("tbl%0d hs", k), int'(sm_if.hsync), tbl[i].hs);
      chk($sformatf("tbl%0d vs", k), int'(sm_if.vsync), tbl[i].vs);
      chk($sformatf("tbl%0d le", k), int'(sm_if.line_end), tbl[i].le);
      chk($sformatf("tbl%0d fe", k), int'(sm_if.frame_end), tbl[i].fe);
      chk($sformatf("tbl%0d fc", k), int'(sm_if.frame_cnt), tbl[i].fc);
    end

    // Enable drop mid-frame, then restart
    start();
    for (int i = 0; i < 460; i++) tick();
    chk("drop pre x", int'(sm_if.pix_x), 10);
    chk("drop pre y", int'(sm_if.pix_y), 5);
    chk("drop pre fc", int'(sm_if.frame_cnt), 1);
    en = 1'b0;
    tick();
    chk("drop x", int'(sm_if.pix_x), 0);
    chk("drop y", int'(sm_if.pix_y), 0);
    chk("drop vis", int'(sm_if.visible), 0);
    chk("drop hs", int'(sm_if.hsync), 0);
    chk("drop vs", int'(sm_if.vsync), 0);
    chk("drop fc", int'(sm_if.frame_cnt), 0);
    cnt_le = 0;
    for (int i = 0; i < 30; i++) begin
      if (sm_if.line_end || sm_if.frame_end) cnt_le++;
      if (sm_if.pix_x != 0) cnt_le++;
      tick();
    end
    chk("idle strobes", cnt_le, 0);
    en = 1'b1;
    tick();
    chk("restart x", int'(sm_if.pix_x), 0);
    chk("restart vis", int'(sm_if.visible), 1);
    chk("restart fc", int'(sm_if.frame_cnt), 0);
    tick();
    chk("restart x+1", int'(sm_if.pix_x), 1);

    // Polarity change while idle lands on the next clk
    en = 1'b0;
    tick();
    chk("idle hs pol1", int'(xga_if.hsync), 0);
    pol = 1'b0;
    tick();
    chk("idle hs pol0", int'(xga_if.hsync), 1);
    chk("idle vs pol0", int'(xga_if.vsync), 1);

    // XGA line, active-low syncs
    en = 1'b1;
    tick();
    cnt_hs = 0;
    cnt_vs = 0;
    first_hs = -1;
    for (int i = 0; i < 1344; i++) begin
      if (!xga_if.hsync) begin
        cnt_hs++;
        if (first_hs < 0) first_hs = int'(xga_if.pix_x);
      end
      if (!xga_if.vsync) cnt_vs++;
      tick();
    end
    chk("pol0 hsync low clks", cnt_hs, 136);
    chk("pol0 hsync low start", first_hs, 1048);
    chk("pol0 vsync low clks", cnt_vs, 0);
    pol = 1'b1;

    // Divide-by-2 pixel clock
    start();
    cnt_le = 0;
    for (int i = 0; i <= 50; i++) begin
      if (i == 1) chk("div k1 x", int'(dv_if.pix_x), 0);
      if (i == 2) chk("div k2 x", int'(dv_if.pix_x), 1);
      if (i == 48) begin
        chk("div k48 x", int'(dv_if.pix_x), 24);
        chk("div k48 le", int'(dv_if.line_end), 0);
      end
      if (i == 49) chk("div k49 le", int'(dv_if.line_end), 1);
      if (i == 50) begin
        chk("div k50 x", int'(dv_if.pix_x), 0);
        chk("div k50 y", int'(dv_if.pix_y), 1);
      end
      if (i < 50 && dv_if.line_end) cnt_le++;
      if (i < 50) tick();
    end
    chk("div line_end width", cnt_le, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
